// File: rtl/cpu_types_pkg.sv
// Types shared by the CPU, cache and memory-side blocks.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);
    int w_cand;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = 0;
        // Scan from the far end so the candidate nearest ptr is the last one written.
        for (int off = N - 1; off >= 0; off--) begin
            w_cand = (int'(ptr) + off) % N;
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = PW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port among all icaches/dcaches: dcache beats icache, cores rotate round-robin.
// Requester k < NCPU is icache k, k >= NCPU is dcache k-NCPU. Counters built with ARB_STATS_EN.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCPU = 2,
    parameter int CNTW = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [NCPU-1:0]             iREN,
    input  logic [NCPU-1:0][31:0]       iaddr,
    output logic [NCPU-1:0]             iwait,
    output logic [NCPU-1:0][31:0]       iload,
    input  logic [NCPU-1:0]             dREN,
    input  logic [NCPU-1:0]             dWEN,
    input  logic [NCPU-1:0][31:0]       daddr,
    input  logic [NCPU-1:0][31:0]       dstore,
    output logic [NCPU-1:0]             dwait,
    output logic [NCPU-1:0][31:0]       dload,
    output logic                        ramREN,
    output logic                        ramWEN,
    output logic [31:0]                 ramaddr,
    output logic [31:0]                 ramstore,
    input  logic [31:0]                 ramload,
    input  ramstate_t                   ramstate,
    output logic [2*NCPU-1:0][CNTW-1:0] grant_cnt,
    output logic [CNTW-1:0]             stall_cnt
);
    localparam int CW = (NCPU > 1) ? $clog2(NCPU) : 1;

    genvar gi;

    arb_state_t      r_state;
    logic [CW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_win_core;
    logic            r_win_d;

    logic [NCPU-1:0] w_d_req;
    logic            w_d_valid;
    logic            w_i_valid;
    logic [CW-1:0]   w_d_idx;
    logic [CW-1:0]   w_i_idx;
    logic            w_win_req;
    logic            w_win_wr;
    logic            w_live;
    logic            w_done;
    word_t           w_win_addr;

    assign w_d_req = dREN | dWEN;

    rr_picker #(.N(NCPU), .PW(CW)) u_pick_d (
        .req   (w_d_req),
        .ptr   (r_rr_ptr),
        .valid (w_d_valid),
        .idx   (w_d_idx)
    );

    rr_picker #(.N(NCPU), .PW(CW)) u_pick_i (
        .req   (iREN),
        .ptr   (r_rr_ptr),
        .valid (w_i_valid),
        .idx   (w_i_idx)
    );

    // The RAM side follows the winner's live signals; a dropped request ends the grant.
    assign w_win_req  = r_win_d ? w_d_req[r_win_core] : iREN[r_win_core];
    assign w_win_wr   = r_win_d & dWEN[r_win_core];
    assign w_win_addr = r_win_d ? daddr[r_win_core] : iaddr[r_win_core];
    assign w_live     = (r_state == GRANT) & w_win_req;
    assign w_done     = w_live & (ramstate == ACCESS);

    assign ramREN   = w_live & ~w_win_wr;
    assign ramWEN   = w_live & w_win_wr;
    assign ramaddr  = w_live ? w_win_addr : '0;
    assign ramstore = (w_live & r_win_d) ? dstore[r_win_core] : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_win_core <= '0;
            r_win_d    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_d_valid || w_i_valid) begin
                        r_state    <= GRANT;
                        r_win_d    <= w_d_valid;
                        r_win_core <= w_d_valid ? w_d_idx : w_i_idx;
                    end
                end
                GRANT: begin
                    if (!w_win_req) begin
                        r_state <= IDLE;
                    end else if (ramstate == ACCESS) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= (r_win_core == CW'(NCPU - 1)) ? '0 : r_win_core + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (gi = 0; gi < NCPU; gi++) begin : g_core
        assign iwait[gi] = ~(w_done & ~r_win_d & (r_win_core == CW'(gi)));
        assign dwait[gi] = ~(w_done &  r_win_d & (r_win_core == CW'(gi)));
        assign iload[gi] = ramload;
        assign dload[gi] = ramload;
    end

`ifdef ARB_STATS_EN
    logic            w_any_req;
    logic [CNTW-1:0] r_stall_cnt;

    assign w_any_req = (|w_d_req) | (|iREN);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (w_any_req && (ramstate != ACCESS) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

    for (gi = 0; gi < 2 * NCPU; gi++) begin : g_grant
        localparam logic IS_D = (gi >= NCPU);
        localparam int   CORE = IS_D ? gi - NCPU : gi;

        logic            w_hit;
        logic [CNTW-1:0] r_cnt;

        assign w_hit = w_done & (r_win_d == IS_D) & (r_win_core == CW'(CORE));

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_cnt <= '0;
            end else if (w_hit && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign grant_cnt[gi] = r_cnt;
    end
`else
    assign stall_cnt = {CNTW{1'b0}};
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed vector table, an ERROR-retry sequence,
// and randomized traffic against a transaction-level reference model.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int N  = 2;
    localparam int CW = 8;

    localparam logic [31:0] A_I0 = 32'h0000_0010;
    localparam logic [31:0] A_I1 = 32'h0000_0014;
    localparam logic [31:0] A_D0 = 32'h0000_0100;
    localparam logic [31:0] A_D1 = 32'h0000_0104;
    localparam logic [31:0] ST0  = 32'hDEAD_BEEF;
    localparam logic [31:0] ST1  = 32'hCAFE_F00D;
    localparam logic [31:0] LD   = 32'h55AA_1234;

    logic                   CLK = 1'b0;
    logic                   nRST = 1'b0;
    logic [N-1:0]           iREN = '0;
    logic [N-1:0][31:0]     iaddr = '0;
    logic [N-1:0]           iwait;
    logic [N-1:0][31:0]     iload;
    logic [N-1:0]           dREN = '0;
    logic [N-1:0]           dWEN = '0;
    logic [N-1:0][31:0]     daddr = '0;
    logic [N-1:0][31:0]     dstore = '0;
    logic [N-1:0]           dwait;
    logic [N-1:0][31:0]     dload;
    logic                   ramREN;
    logic                   ramWEN;
    logic [31:0]            ramaddr;
    logic [31:0]            ramstore;
    logic [31:0]            ramload = '0;
    ramstate_t              ramstate = FREE;
    logic [2*N-1:0][CW-1:0] grant_cnt;
    logic [CW-1:0]          stall_cnt;

    always #5 CLK = ~CLK;

    cache_mem_arbiter #(.NCPU(N), .CNTW(CW)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One cycle: inputs, then expected RAM side and waits ({dwait, iwait}).
    typedef struct {
        logic       rst;
        logic [1:0] ir;
        logic [1:0] dr;
        logic [1:0] dw;
        ramstate_t  rs;
        logic       chk;
        logic       er;
        logic       ew;
        logic [31:0] ea;
        logic [31:0] es;
        logic [3:0] w;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] ir, input logic [1:0] dr,
                                input logic [1:0] dw, input ramstate_t rs, input logic chk,
                                input logic er, input logic ew, input logic [31:0] ea,
                                input logic [31:0] es, input logic [3:0] w);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs; v.chk = chk;
        v.er = er; v.ew = ew; v.ea = ea; v.es = es; v.w = w;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        @(posedge CLK); #1;
        nRST = ~v.rst; iREN = v.ir; dREN = v.dr; dWEN = v.dw; ramstate = v.rs;
        #4;
        if (v.chk) begin
            check({tag, "_en"}, {ramREN, ramWEN}, {v.er, v.ew});
            if (v.er || v.ew || v.rst) check({tag, "_addr"}, ramaddr, v.ea);
            if (v.ew || v.rst) check({tag, "_store"}, ramstore, v.es);
        end
        check({tag, "_wait"}, {dwait, iwait}, v.w);
        for (int k = 0; k < 2 * N; k++) begin
            if (!v.w[k]) check({tag, "_load"}, (k < N) ? iload[k] : dload[k - N], ramload);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] v, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (v[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    // Reference model state: current owner (-1 none), rotation pointer, counters.
    int          m_owner;
    int          m_ptr;
    int          m_gcnt[2*N];
    int          m_stall;
    logic        act[2*N];
    logic        done_k[2*N];
    logic [31:0] r_addr[2*N];
    logic [31:0] r_data[2*N];
    int          kind[2*N];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  e_wait;
        logic        e_ren, e_wen, any, live, wr;
        logic [31:0] e_addr, e_store;
        int          k, c, e_grant, e_stall;

        iaddr[0] = A_I0; iaddr[1] = A_I1;
        daddr[0] = A_D0; daddr[1] = A_D1;
        dstore[0] = ST0; dstore[1] = ST1;
        ramload = LD;

        // rst, ir, dr, dw, rs, chk, ren, wen, addr, store, waits
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        // dcache1 vs icache0 arriving together
        vecs.push_back(mk(0, 2'b01, 2'b10, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b01, 2'b10, 2'b00, BUSY,   1, 1, 0, A_D1, 0,   4'hF));
        vecs.push_back(mk(0, 2'b01, 2'b10, 2'b00, ACCESS, 1, 1, 0, A_D1, 0,   4'b0111));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, ACCESS, 1, 1, 0, A_I0, 0,   4'b1110));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        // reset in the middle of a write grant
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, FREE,   1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, BUSY,   1, 0, 1, A_D0, ST0, 4'hF));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b01, BUSY,   1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        // both dcaches held continuously from ptr=0: order 0,1,0,1
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, ACCESS, 1, 1, 0, A_D0, 0,   4'b1011));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, ACCESS, 1, 1, 0, A_D1, 0,   4'b0111));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, ACCESS, 1, 1, 0, A_D0, 0,   4'b1011));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, ACCESS, 1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, ACCESS, 1, 1, 0, A_D1, 0,   4'b0111));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        // dcache0 write
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, FREE,   1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, BUSY,   1, 0, 1, A_D0, ST0, 4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b01, ACCESS, 1, 0, 1, A_D0, ST0, 4'b1011));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        // icache1 aborts while BUSY; pointer stays at 1 so icache1 wins the next tie
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, BUSY,   1, 1, 0, A_I1, 0,   4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, BUSY,   0, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, ACCESS, 1, 1, 0, A_I1, 0,   4'b1101));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0,   4'hF));

        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // ERROR retry: enables held through three ERROR cycles, then one completion.
        apply_vec(mk(1, 2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0, 4'hF), "err_rst");
        apply_vec(mk(0, 2'b00, 2'b10, 2'b00, FREE,   1, 0, 0, 0,    0, 4'hF), "err_idle");
        for (int e = 0; e < 3; e++)
            apply_vec(mk(0, 2'b00, 2'b10, 2'b00, ERROR, 1, 1, 0, A_D1, 0, 4'hF),
                      $sformatf("err_retry%0d", e));
        apply_vec(mk(0, 2'b00, 2'b10, 2'b00, ACCESS, 1, 1, 0, A_D1, 0, 4'b0111), "err_access");
        apply_vec(mk(0, 2'b00, 2'b00, 2'b00, FREE,   1, 0, 0, 0,    0, 4'hF), "err_drop");
`ifdef ARB_STATS_EN
        e_stall = 4;
`else
        e_stall = 0;
`endif
        check("err_stall_cnt", stall_cnt, e_stall);
        for (int g = 0; g < 2 * N; g++)
            check($sformatf("err_grant_cnt%0d", g), grant_cnt[g], (g == 3) ? e_stall / 4 : 0);

        // Randomized traffic against the reference model.
        apply_vec(mk(1, 2'b00, 2'b00, 2'b00, FREE, 1, 0, 0, 0, 0, 4'hF), "rnd_rst");
        m_owner = -1; m_ptr = 0; m_stall = 0;
        for (int g = 0; g < 2 * N; g++) begin
            m_gcnt[g] = 0; act[g] = 0; done_k[g] = 0; kind[g] = 0; r_addr[g] = 0; r_data[g] = 0;
        end

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge CLK); #1;
            nRST = 1'b1;
            for (int g = 0; g < 2 * N; g++) begin
                if (done_k[g]) act[g] = 0;
                else if (act[g] && $urandom_range(0, 39) == 0) act[g] = 0;
                else if (!act[g] && $urandom_range(0, 2) == 0) begin
                    act[g] = 1; r_addr[g] = $urandom; r_data[g] = $urandom;
                    kind[g] = $urandom_range(0, 2);
                end
                done_k[g] = 0;
            end
            for (int p = 0; p < N; p++) begin
                iREN[p]   = act[p];
                iaddr[p]  = r_addr[p];
                dREN[p]   = act[N + p] && (kind[N + p] != 1);
                dWEN[p]   = act[N + p] && (kind[N + p] != 0);
                daddr[p]  = r_addr[N + p];
                dstore[p] = r_data[N + p];
            end
            ramstate = ramstate_t'($urandom_range(0, 3));
            ramload  = $urandom;
            #4;

            any = ((dREN | dWEN) != 0) || (iREN != 0);
            if (any && ramstate != ACCESS && m_stall < 255) m_stall++;
            e_ren = 0; e_wen = 0; e_wait = 4'hF; e_addr = 0; e_store = 0;
            k = -1;
            if (m_owner < 0) begin
                if ((dREN | dWEN) != 0) m_owner = N + first_from(dREN | dWEN, m_ptr);
                else if (iREN != 0) m_owner = first_from(iREN, m_ptr);
            end else begin
                c    = (m_owner < N) ? m_owner : m_owner - N;
                live = (m_owner < N) ? iREN[c] : (dREN[c] | dWEN[c]);
                if (!live) m_owner = -1;
                else begin
                    wr      = (m_owner >= N) && dWEN[c];
                    e_wen   = wr;
                    e_ren   = !wr;
                    e_addr  = (m_owner < N) ? iaddr[c] : daddr[c];
                    e_store = dstore[c];
                    if (ramstate == ACCESS) begin
                        k = m_owner;
                        e_wait[k] = 1'b0;
                        done_k[k] = 1;
                        if (m_gcnt[k] < 255) m_gcnt[k]++;
                        m_ptr = (c + 1) % N;
                        m_owner = -1;
                        $display("txn cyc=%0d req=%0d %s addr=%h", cyc, k, wr ? "wr" : "rd", e_addr);
                    end
                end
            end

            check($sformatf("rnd%0d_ctl", cyc), {ramREN, ramWEN, dwait, iwait}, {e_ren, e_wen, e_wait});
            if (e_ren || e_wen) check($sformatf("rnd%0d_addr", cyc), ramaddr, e_addr);
            if (e_wen) check($sformatf("rnd%0d_store", cyc), ramstore, e_store);
            if (k >= 0) check($sformatf("rnd%0d_load", cyc), (k < N) ? iload[k] : dload[k - N], ramload);
        end

        @(posedge CLK); #1;
        iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
        repeat (2) @(posedge CLK);
        #4;
        for (int g = 0; g < 2 * N; g++) begin
`ifdef ARB_STATS_EN
            e_grant = m_gcnt[g];
`else
            e_grant = 0;
`endif
            check($sformatf("rnd_grant_cnt%0d", g), grant_cnt[g], e_grant);
        end
`ifdef ARB_STATS_EN
        e_stall = m_stall;
`else
        e_stall = 0;
`endif
        check("rnd_stall_cnt", stall_cnt, e_stall);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
